// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RESP  = 2'd2,
        ABORT = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_e;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned TIMEOUT_DEF = 16;

    // Watchdog counter width; the counter only ever needs to reach TIMEOUT-1.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data load/store (D),
// one transaction at a time, alternating on contention, with a stuck-access watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_ack,
    output logic            i_err,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ack,
    output logic            d_err,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    arb_state_e      state_q,     state_d;
    requester_e      last_q,      last_d;
    requester_e      grant;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic            cap_we_q,    cap_we_d;
    logic [XLEN-1:0] cap_addr_q,  cap_addr_d;
    logic [XLEN-1:0] cap_wdata_q, cap_wdata_d;
    logic            mem_req_q,   mem_req_d;
    logic            mem_we_q,    mem_we_d;
    logic [XLEN-1:0] mem_addr_q,  mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic            i_ack_q,     i_ack_d;
    logic            i_err_q,     i_err_d;
    logic            d_ack_q,     d_ack_d;
    logic            d_err_q,     d_err_d;
    logic [XLEN-1:0] i_rdata_q,   i_rdata_d;
    logic [XLEN-1:0] d_rdata_q,   d_rdata_d;

    // Next-state, capture and response logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant       = REQ_I;
        cnt_d       = cnt_q;
        cap_we_d    = cap_we_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = 1'b0;
        i_err_d     = 1'b0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    if (i_req && d_req) begin
                        grant = (last_q == REQ_I) ? REQ_D : REQ_I;
                    end else begin
                        grant = i_req ? REQ_I : REQ_D;
                    end
                    last_d  = grant;
                    cnt_d   = '0;
                    state_d = BUSY;
                    if (grant == REQ_I) begin
                        cap_we_d    = 1'b0;
                        cap_addr_d  = i_addr;
                        cap_wdata_d = '0;
                    end else begin
                        cap_we_d    = d_we;
                        cap_addr_d  = d_addr;
                        cap_wdata_d = d_we ? d_wdata : '0;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d = RESP;
                    if (last_q == REQ_I) begin
                        i_rdata_d = mem_rdata;
                        i_ack_d   = 1'b1;
                    end else begin
                        d_rdata_d = mem_rdata;
                        d_ack_d   = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ABORT;
                    i_err_d = (last_q == REQ_I);
                    d_err_d = (last_q == REQ_D);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Memory side only ever reflects the captured request while BUSY.
        mem_req_d   = (state_d == BUSY);
        mem_we_d    = mem_req_d & cap_we_d;
        mem_addr_d  = mem_req_d ? cap_addr_d  : '0;
        mem_wdata_d = mem_req_d ? cap_wdata_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= REQ_D;
            cnt_q       <= '0;
            cap_we_q    <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            cap_we_q    <= cap_we_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            i_err_q     <= i_err_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ack     = i_ack_q;
    assign i_err     = i_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of grant order, latency and data.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;
    localparam int TO   = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_req = 1'b0;
    logic [XLEN-1:0] i_addr = '0;
    logic            i_ack, i_err;
    logic [XLEN-1:0] i_rdata;
    logic            d_req = 1'b0;
    logic            d_we = 1'b0;
    logic [XLEN-1:0] d_addr = '0;
    logic [XLEN-1:0] d_wdata = '0;
    logic            d_ack, d_err;
    logic [XLEN-1:0] d_rdata;
    logic            mem_req, mem_we;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic            mem_ack = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;
    bit last_d = 1'b1;
    logic [31:0] exp_ir = '0;
    logic [31:0] exp_dr = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic raise_i();
        i_addr = $urandom;
        i_req  = 1'b1;
    endtask

    task automatic raise_d();
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_we    = 1'($urandom_range(0, 1));
        d_req   = 1'b1;
    endtask

    // Plays the memory: waits for mem_req, acks after `delay` BUSY cycles (-1 = never),
    // and returns at the cycle a response pulse is visible.
    task automatic serve(input int delay, input logic [31:0] rd, output bit got,
                         output logic we, output logic [31:0] addr, output logic [31:0] wd,
                         output logic [3:0] who, output int lat, output bit stable);
        got = 1'b0; we = 1'b0; addr = '0; wd = '0; who = '0; lat = -1; stable = 1'b1;
        for (int w = 0; w < 8 && !got; w++) begin
            tick();
            mem_ack = 1'b0;
            if (mem_req) got = 1'b1;
        end
        if (!got) return;
        we = mem_we; addr = mem_addr; wd = mem_wdata;
        for (int k = 0; k <= TO + 4; k++) begin
            if (i_ack || d_ack || i_err || d_err) begin
                who = {d_err, i_err, d_ack, i_ack};
                lat = k;
                mem_ack = 1'b0;
                return;
            end
            if (!mem_req || mem_we !== we || mem_addr !== addr || mem_wdata !== wd) stable = 1'b0;
            mem_ack   = (k == delay);
            mem_rdata = (k == delay) ? rd : $urandom;
            tick();
        end
        mem_ack = 1'b0;
    endtask

    // One transaction predicted from the arbitration rules and checked end to end.
    task automatic txn(input int delay, input logic [31:0] rd, input string tag);
        bit g_d, got, stable, timed;
        logic we, exp_we;
        logic [31:0] addr, wd, exp_addr, exp_wd;
        logic [3:0] who, exp_who;
        int lat, exp_lat;
        g_d      = (i_req && d_req) ? !last_d : d_req;
        last_d   = g_d;
        exp_we   = g_d ? d_we : 1'b0;
        exp_addr = g_d ? d_addr : i_addr;
        exp_wd   = (g_d && d_we) ? d_wdata : 32'h0;
        timed    = !(delay >= 0 && delay <= TO - 1);
        exp_who  = timed ? (g_d ? 4'b1000 : 4'b0100) : (g_d ? 4'b0010 : 4'b0001);
        exp_lat  = timed ? TO : delay + 1;
        serve(delay, rd, got, we, addr, wd, who, lat, stable);
        chk({tag, ":mem_req_seen"}, 32'(got), 32'd1);
        chk({tag, ":mem_we"}, 32'(we), 32'(exp_we));
        chk({tag, ":mem_addr"}, addr, exp_addr);
        chk({tag, ":mem_wdata"}, wd, exp_wd);
        chk({tag, ":mem_stable"}, 32'(stable), 32'd1);
        chk({tag, ":response"}, 32'(who), 32'(exp_who));
        chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        if (!timed) begin
            if (g_d) exp_dr = rd;
            else     exp_ir = rd;
        end
        chk({tag, ":i_rdata"}, i_rdata, exp_ir);
        chk({tag, ":d_rdata"}, d_rdata, exp_dr);
        if (g_d) d_req = 1'b0;
        else     i_req = 1'b0;
        tick();
        chk({tag, ":pulse_width"}, 32'({i_ack, i_err, d_ack, d_err}), 32'd0);
        chk({tag, ":idle_gap"}, 32'(mem_req), 32'd0);
        // Stray ack while IDLE must be ignored.
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
    endtask

    initial begin
        int delay, r;

        // 1: reset holds everything quiet even with both requests pending
        i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        repeat (3) tick();
        chk("reset:mem_req", 32'(mem_req), 32'd0);
        chk("reset:pulses", 32'({i_ack, i_err, d_ack, d_err}), 32'd0);
        chk("reset:rdata", i_rdata | d_rdata, 32'd0);
        rst_n = 1'b1;
        txn(0, $urandom, "reset_first_I");
        txn(2, $urandom, "reset_then_D");

        // 2: fetch
        i_addr = 32'h100; i_req = 1'b1;
        txn(1, 32'hDEADBEEF, "fetch");
        chk("fetch:i_rdata_value", i_rdata, 32'hDEADBEEF);

        // 3: store
        d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_req = 1'b1;
        txn(0, $urandom, "store");

        // 4: held contention alternates I,D,I,D
        raise_i(); raise_d();
        for (int n = 0; n < 4; n++) begin
            chk("contention:grant_pred", 32'(!last_d), 32'(n % 2));
            txn(n, $urandom, "contention");
            if (n % 2 == 0) raise_i();
            else            raise_d();
        end
        i_req = 1'b0; d_req = 1'b0;
        tick(); tick();

        // 5: timeout on D, D data untouched, then I served; ack on the last allowed cycle
        raise_d();
        txn(-1, $urandom, "timeout_d");
        raise_i();
        txn(0, $urandom, "after_timeout_i");
        raise_d();
        txn(TO - 1, $urandom, "ack_last_cycle");

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            if (!i_req && $urandom_range(0, 9) < 6) raise_i();
            if (!d_req && $urandom_range(0, 9) < 6) raise_d();
            if (!i_req && !d_req) begin
                if ($urandom_range(0, 1) == 1) raise_d();
                else                           raise_i();
            end
            r = int'($urandom_range(0, 9));
            delay = (r == 0) ? -1 : (r == 1) ? TO - 1 : int'($urandom_range(0, 4));
            txn(delay, $urandom, "random");
        end

        // 6: async reset mid-BUSY
        i_req = 1'b0;
        if (!d_req) raise_d();
        begin
            bit seen = 1'b0;
            for (int w = 0; w < 8 && !seen; w++) begin
                tick();
                mem_ack = 1'b0;
                if (mem_req) seen = 1'b1;
            end
            chk("rst_busy:mem_req_before", 32'(seen), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1 chk("rst_busy:mem_req_drop", 32'(mem_req), 32'd0);
        i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        last_d = 1'b1; exp_ir = '0; exp_dr = '0;
        #10 rst_n = 1'b1;
        begin
            logic [3:0] seen_pulse = '0;
            logic       seen_req = 1'b0;
            for (int k = 0; k < 6; k++) begin
                tick();
                seen_pulse |= {i_ack, i_err, d_ack, d_err};
                seen_req   |= mem_req;
            end
            chk("rst_busy:no_response", 32'(seen_pulse), 32'd0);
            chk("rst_busy:no_mem_req", 32'(seen_req), 32'd0);
        end
        raise_i(); raise_d();
        txn(1, $urandom, "post_reset_I");
        txn(0, $urandom, "post_reset_D");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
